// File: rtl/reg_bank_arbiter.sv
// Two-requester arbiter for a bank of tri-stated registers sharing one D and one Q bus.
// Bank strobes are decoded from registered state, so an async reset removes them at once.
module reg_bank_arbiter #(
    parameter int NrOfRegs = 8,
    parameter int AddrBits = 3,
    parameter int NrOfBits = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req0,
    input  logic                req1,
    input  logic                we0,
    input  logic                we1,
    input  logic [AddrBits-1:0] addr0,
    input  logic [AddrBits-1:0] addr1,
    input  logic [NrOfBits-1:0] wdata0,
    input  logic [NrOfBits-1:0] wdata1,
    output logic                grant0,
    output logic                grant1,
    output logic                rvalid0,
    output logic                rvalid1,
    output logic                err0,
    output logic                err1,
    output logic [NrOfBits-1:0] rdata,
    output logic [NrOfRegs-1:0] bank_cs,
    output logic [NrOfRegs-1:0] bank_ce,
    output logic                bank_tick,
    output logic [NrOfBits-1:0] bank_d,
    input  logic [NrOfBits-1:0] bank_q
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [AddrBits:0] NrRegsW = (AddrBits + 1)'(NrOfRegs);

    state_e                state_q, state_d;
    logic                  win_q, win_d;
    logic                  we_q, we_d;
    logic [AddrBits-1:0]   addr_q, addr_d;
    logic [NrOfBits-1:0]   wdata_q, wdata_d;
    logic [NrOfBits-1:0]   rdata_q, rdata_d;

    logic                  addr_ok_s;
    logic [NrOfRegs-1:0]   sel_s;
    logic                  acc_s;
    logic                  wr_s;
    logic                  rd_s;
    logic                  pick_s;

    // Address range check and one-hot register select from the latched address.
    always_comb begin
        addr_ok_s = ({1'b0, addr_q} < NrRegsW);
        sel_s     = '0;
        for (int i = 0; i < NrOfRegs; i++) begin
            sel_s[i] = (addr_q == AddrBits'(i));
        end
    end

    // Next-state logic; win_q doubles as last_winner for round-robin tie breaking.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        pick_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    pick_s  = (req0 && req1) ? ~win_q : req1;
                    win_d   = pick_s;
                    we_d    = pick_s ? we1 : we0;
                    addr_d  = pick_s ? addr1 : addr0;
                    wdata_d = pick_s ? wdata1 : wdata0;
                    state_d = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                    rdata_d = addr_ok_s ? bank_q : '0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transaction registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Bank strobes and handshake pulses decoded purely from registered state.
    always_comb begin
        acc_s     = (state_q == ACCESS);
        wr_s      = acc_s && we_q && addr_ok_s;
        rd_s      = acc_s && !we_q && addr_ok_s;
        grant0    = acc_s && !win_q;
        grant1    = acc_s && win_q;
        err0      = grant0 && !addr_ok_s;
        err1      = grant1 && !addr_ok_s;
        rvalid0   = (state_q == DONE) && !win_q;
        rvalid1   = (state_q == DONE) && win_q;
        bank_tick = wr_s;
        bank_ce   = wr_s ? sel_s : '0;
        bank_d    = wr_s ? wdata_q : '0;
        bank_cs   = rd_s ? ~sel_s : '1;
        rdata     = rdata_q;
    end

endmodule
